btn_mode_router: RTL
====================

BTN_MODE_ROUTER -- requirements
Module: btn_mode_router

Interface
REQ-001 Parameter N_BTN, default 3: number of button channels, range 1..8.
REQ-002 Parameter N_MODE, default 2: number of routing modes, range 2..4.
REQ-003 Parameter DB_CYCLES, default 100000: consecutive stable synchronised samples required before the debounced level changes, minimum 2.
REQ-004 Parameter HOLD_CYCLES, default 50000000: cycles a debounced press must persist before auto-repeat starts.
REQ-005 Parameter REPEAT_CYCLES, default 10000000: auto-repeat pulse period.
REQ-006 Parameter REPEAT_MASK, N_BTN bits, default all 0: bit i = 1 enables auto-repeat on channel i.
REQ-007 clk  in  1  single system clock, all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 btn  in  N_BTN  raw, asynchronous, bouncing button inputs, active high.
REQ-010 mode  in  MW = max(1, clog2(N_MODE))  current routing mode, for example from a slide switch.
REQ-011 o_pulse  out  N_MODE*N_BTN  one-cycle event pulses; bit m*N_BTN+i = channel i in mode m.
REQ-012 o_level  out  N_BTN  debounced level per channel, independent of mode.
REQ-013 o_held  out  N_BTN  high while channel i is in the REPEAT state.

Function
REQ-014 Each btn bit passes through a 2-flop synchroniser before any other logic.
REQ-015 Debounce: per-channel counter increments while the synchronised value differs from o_level and clears to 0 when it matches; when the count reaches DB_CYCLES, o_level toggles and the counter clears.
REQ-016 Per-channel FSM states: IDLE, PRESS, REPEAT.
REQ-017 IDLE->PRESS on an o_level rise; this latches the current mode as the channel's owner mode and emits one press pulse.
REQ-018 PRESS->REPEAT when the hold counter reaches HOLD_CYCLES and REPEAT_MASK[i]=1; with the mask bit at 0 the channel stays in PRESS until release.
REQ-019 REPEAT emits one pulse each REPEAT_CYCLES cycles; the first repeat pulse comes REPEAT_CYCLES after entering REPEAT.
REQ-020 PRESS or REPEAT -> IDLE on an o_level fall; the hold and repeat counters clear and no pulse is emitted.
REQ-021 Pulses are registered: a press pulse appears in the cycle after the o_level rise and lasts exactly one cycle.
REQ-022 Pulses route only to the owner mode slice; all other slices stay 0.
REQ-023 A mode change during PRESS or REPEAT does not re-route; the new mode applies from the next press.
REQ-024 If the latched owner mode is >= N_MODE, all pulses for that press are suppressed; o_level still tracks the input.
REQ-025 Channels are fully independent; simultaneous presses on several channels each produce their own pulses in the same cycle.
REQ-026 Counters saturate and never wrap; counter widths are clog2 of the respective parameter plus 1.
REQ-027 A bounce shorter than DB_CYCLES produces no o_level change and no pulse.

Reset
REQ-028 On rst high, asynchronously: synchronisers, o_level, o_pulse, o_held and all counters go to 0, every FSM goes to IDLE, and owner modes go to 0.
REQ-029 A button held through reset release is seen as a new press only after DB_CYCLES stable samples; the press pulse then goes to the mode current at that time.
REQ-030 Reset asserted mid-REPEAT stops pulses in the same cycle, since the output registers are cleared asynchronously.

Structure
REQ-031 Shared package btn_ctrl_pkg holds the FSM state encoding (IDLE=0, PRESS=1, REPEAT=2) and the default timing constants.
REQ-032 One sub-module, btn_db_channel, covers one channel: synchroniser, debounce, FSM and counters, with outputs level, event pulse and held. The top instantiates N_BTN copies plus the mode latch and routing.

Verification
Bench parameters: DB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, N_BTN=3, N_MODE=2, REPEAT_MASK=3'b010.
- V1: btn[0] high for 3 cycles, then low -> o_level[0] stays 0 and o_pulse stays 0.
- V2: mode=0, btn[2] held for 10 cycles -> o_level[2] rises 6 cycles after the raw edge (2 sync + 4 debounce); o_pulse[2] is high for 1 cycle, one cycle later; o_pulse[5] stays 0.
- V3: mode=1, btn[1] held for 50 cycles -> one press pulse on bit 4; o_held[1] rises 20 cycles after the pulse; repeat pulses follow every 5 cycles; no pulse on release.
- V4: mode=0, press btn[0], switch mode to 1 mid-hold, release, press again -> first pulse on bit 0, second pulse on bit 3.
- V5: btn[0] and btn[2] rise in the same cycle, mode=1 -> bits 3 and 5 pulse in the same cycle.
- V6: rst pulsed during REPEAT on btn[1] with the button still held -> all outputs go to 0 immediately; after release of rst, one press pulse follows 6+1 cycles later.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared definitions for the button controller: per-channel FSM state
// encoding, default timing constants and the mode-bus width helper.
package btn_ctrl_pkg;

    // Per-channel press FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRESS  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Default configuration
    localparam int DEF_N_BTN         = 3;
    localparam int DEF_N_MODE        = 2;
    localparam int DEF_DB_CYCLES     = 100000;
    localparam int DEF_HOLD_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;

    // Width of the mode bus: at least one bit even for two modes
    function automatic int mode_width(input int n_mode);
        return (n_mode > 2) ? $clog2(n_mode) : 1;
    endfunction

endpackage

// File: rtl/btn_db_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, and the
// IDLE/PRESS/REPEAT FSM with hold and repeat counters. The start and fire
// strobes are next-edge indications; the top registers them into o_pulse
// together with the owner mode, so pulses land one cycle after the level rise.
module btn_db_channel
    import btn_ctrl_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic start,
    output logic fire,
    output logic held
);

    localparam int DBW = $clog2(DB_CYCLES) + 1;
    localparam int HW  = $clog2(HOLD_CYCLES) + 1;
    localparam int RW  = $clog2(REPEAT_CYCLES) + 1;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_TOP  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);
    localparam logic [RW-1:0]  REP_LAST  = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0]  REP_ONE   = RW'(1);

    logic [1:0]     sync_r;
    logic           level_r;
    logic [DBW-1:0] db_cnt_r;
    logic [1:0]     state_r, state_s;
    logic [HW-1:0]  hold_cnt_r, hold_s;
    logic [RW-1:0]  rep_cnt_r, rep_s;
    logic           held_r;

    // Bring the raw button into the clock domain before anything looks at it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    // Debounce: count consecutive samples that disagree with the level, toggle on the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r  <= 1'b0;
            db_cnt_r <= '0;
        end else if (sync_r[1] != level_r) begin
            if (db_cnt_r == DB_LAST) begin
                level_r  <= ~level_r;
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + DB_ONE;
            end
        end else begin
            db_cnt_r <= '0;
        end
    end

    // Next-state, counter and strobe logic; a release always wins and never pulses
    always_comb begin
        state_s = state_r;
        hold_s  = hold_cnt_r;
        rep_s   = rep_cnt_r;
        start   = 1'b0;
        fire    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hold_s = '0;
                rep_s  = '0;
                if (level_r) begin
                    state_s = ST_PRESS;
                    start   = 1'b1;
                    fire    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (!level_r) begin
                    state_s = ST_IDLE;
                    hold_s  = '0;
                    rep_s   = '0;
                end else if (REPEAT_EN && (hold_cnt_r == HOLD_LAST)) begin
                    state_s = ST_REPEAT;
                    hold_s  = '0;
                    rep_s   = '0;
                end else if (hold_cnt_r != HOLD_TOP) begin
                    hold_s = hold_cnt_r + HOLD_ONE;
                end else begin
                    hold_s = hold_cnt_r;
                end
            end
            ST_REPEAT: begin
                if (!level_r) begin
                    state_s = ST_IDLE;
                    hold_s  = '0;
                    rep_s   = '0;
                end else if (rep_cnt_r == REP_LAST) begin
                    fire  = 1'b1;
                    rep_s = '0;
                end else begin
                    rep_s = rep_cnt_r + REP_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                hold_s  = '0;
                rep_s   = '0;
            end
        endcase
    end

    // FSM state, counters and the registered held flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= '0;
            rep_cnt_r  <= '0;
            held_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_s;
            rep_cnt_r  <= rep_s;
            held_r     <= (state_s == ST_REPEAT);
        end
    end

    assign level = level_r;
    assign held  = held_r;

endmodule

// File: rtl/btn_mode_router.sv
// Debounced button router: N_BTN independent channels, each press owned by
// the mode present when it started; pulses go only to that mode's slice.
module btn_mode_router
    import btn_ctrl_pkg::*;
#(
    parameter int               N_BTN         = DEF_N_BTN,
    parameter int               N_MODE        = DEF_N_MODE,
    parameter int               DB_CYCLES     = DEF_DB_CYCLES,
    parameter int               HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int               REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = '0,
    localparam int              MW            = mode_width(N_MODE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_BTN-1:0]        btn,
    input  logic [MW-1:0]           mode,
    output logic [N_MODE*N_BTN-1:0] o_pulse,
    output logic [N_BTN-1:0]        o_level,
    output logic [N_BTN-1:0]        o_held
);

    logic [N_BTN-1:0]        start_s;
    logic [N_BTN-1:0]        fire_s;
    logic [MW-1:0]           owner_r     [N_BTN];
    logic [MW-1:0]           owner_eff_s [N_BTN];
    logic [N_MODE*N_BTN-1:0] pulse_s;
    logic [N_MODE*N_BTN-1:0] pulse_r;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_db_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .level(o_level[i]),
            .start(start_s[i]),
            .fire (fire_s[i]),
            .held (o_held[i])
        );
    end

    // Latch the owner mode at the start of each press; later mode changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                owner_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                owner_r[i] <= start_s[i] ? mode : owner_r[i];
            end
        end
    end

    // Route each strobe to its owner slice; owners >= N_MODE match no slice and are dropped
    always_comb begin
        pulse_s = '0;
        for (int i = 0; i < N_BTN; i++) begin
            owner_eff_s[i] = start_s[i] ? mode : owner_r[i];
            for (int m = 0; m < N_MODE; m++) begin
                pulse_s[m*N_BTN + i] = fire_s[i] && (owner_eff_s[i] == MW'(m));
            end
        end
    end

    // Registered pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_r <= '0;
        end else begin
            pulse_r <= pulse_s;
        end
    end

    assign o_pulse = pulse_r;

endmodule
